// File: rtl/gpio_irq_if.sv
// CPU-side register bus of gpio_irq: chip select, write strobe, register select,
// write data and registered read data.
interface gpio_irq_if;
    logic       cs;
    logic       we;
    logic [4:0] rs;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, output we, output rs, output din, input dout);
    modport slave  (input cs, input we, input rs, input din, output dout);
endinterface

// File: rtl/gpio_irq.sv
// Byte-addressed GPIO block: output/direction registers, synchronised pin inputs,
// per-pin edge capture into a write-1-to-clear status register and a level interrupt.
module gpio_irq #(
    parameter int              WIDTH       = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    gpio_irq_if.slave        bus,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [2:0] {
        REG_OUT  = 3'd0,
        REG_DIR  = 3'd1,
        REG_PIN  = 3'd2,
        REG_IEN  = 3'd3,
        REG_EDGE = 3'd4,
        REG_BOTH = 3'd5,
        REG_STAT = 3'd6,
        REG_NONE = 3'd7
    } reg_idx_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] both_q, both_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [7:0]       dout_q, dout_d;
    logic             irq_q, irq_d;
    logic [ARM_W-1:0] arm_q, arm_d;

    reg_idx_e         idx;
    logic [1:0]       lane;
    logic             wr_en;
    logic             rd_en;
    logic             armed;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] pin_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_sel;
    logic [31:0]      rd_word;

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_val,
                                               input logic [WIDTH-1:0] mask,
                                               input logic [WIDTH-1:0] data);
        return (old_val & ~mask) | (data & mask);
    endfunction

    always_comb begin
        idx   = reg_idx_e'(bus.rs[4:2]);
        lane  = bus.rs[1:0];
        wr_en = bus.cs & bus.we;
        rd_en = bus.cs & ~bus.we;

        // Bits beyond WIDTH simply do not exist, so unbacked lanes get an empty mask.
        for (int i = 0; i < WIDTH; i++) begin
            lane_mask[i] = ((i / 8) == int'(lane));
            wr_data[i]   = bus.din[i % 8];
        end

        pin_val = sync_q[SYNC_STAGES-1];
        armed   = (arm_q == ARM_W'(ARM_CYCLES));
        arm_d   = armed ? arm_q : arm_q + ARM_W'(1);

        rise = pin_val & ~prev_q;
        fall = ~pin_val & prev_q;
        hit  = '0;
        if (armed) begin
            hit = (both_q & (rise | fall)) | (~both_q & ((~edge_q & rise) | (edge_q & fall)));
        end

        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        edge_d = edge_q;
        both_d = both_q;
        clr    = '0;
        if (wr_en) begin
            case (idx)
                REG_OUT:  out_d  = merge(out_q,  lane_mask, wr_data);
                REG_DIR:  dir_d  = merge(dir_q,  lane_mask, wr_data);
                REG_IEN:  ien_d  = merge(ien_q,  lane_mask, wr_data);
                REG_EDGE: edge_d = merge(edge_q, lane_mask, wr_data);
                REG_BOTH: both_d = merge(both_q, lane_mask, wr_data);
                REG_STAT: clr    = wr_data & lane_mask;
                default:  clr    = '0;
            endcase
        end

        // A fresh edge outranks a same-cycle clear so no event is ever lost.
        stat_d = (stat_q & ~clr) | hit;
        irq_d  = |(stat_q & ien_q);

        sync_d[0] = gpio_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = pin_val;

        case (idx)
            REG_OUT:  rd_sel = out_q;
            REG_DIR:  rd_sel = dir_q;
            REG_PIN:  rd_sel = pin_val;
            REG_IEN:  rd_sel = ien_q;
            REG_EDGE: rd_sel = edge_q;
            REG_BOTH: rd_sel = both_q;
            REG_STAT: rd_sel = stat_q;
            default:  rd_sel = '0;
        endcase
        rd_word              = '0;
        rd_word[WIDTH-1:0]   = rd_sel;
        dout_d = rd_en ? rd_word[{lane, 3'b000} +: 8] : dout_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= OUT_RESET;
            dir_q  <= '0;
            ien_q  <= '0;
            edge_q <= '0;
            both_q <= '0;
            stat_q <= '0;
            prev_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            dout_q <= '0;
            irq_q  <= 1'b0;
            arm_q  <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            ien_q  <= ien_d;
            edge_q <= edge_d;
            both_q <= both_d;
            stat_q <= stat_d;
            prev_q <= prev_d;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            dout_q <= dout_d;
            irq_q  <= irq_d;
            arm_q  <= arm_d;
        end
    end

    assign gpio_o   = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq (WIDTH=12, two sync stages, OUT_RESET=0x3C)
// against a per-cycle behavioural model of the register file and edge capture.
module tb_gpio_irq;
    localparam int               WIDTH   = 12;
    localparam int               SYNC    = 2;
    localparam logic [WIDTH-1:0] OUT_RST = 12'h03C;
    localparam logic [31:0]      WMASK   = 32'h0000_0FFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] gpio_i;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    gpio_irq_if bus();

    gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .OUT_RESET(OUT_RST)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [31:0] m_out, m_dir, m_ien, m_edge, m_both, m_stat, m_prev;
    logic [31:0] m_pipe [SYNC];
    logic [7:0]  m_dout;
    logic        m_irq;
    int          m_cycles;
    logic [31:0] pins = 32'h0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0: return m_out;
            1: return m_dir;
            2: return m_pipe[SYNC-1];
            3: return m_ien;
            4: return m_edge;
            5: return m_both;
            6: return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_out = 32'(OUT_RST); m_dir = 0; m_ien = 0; m_edge = 0; m_both = 0; m_stat = 0;
        m_prev = 0; m_dout = 0; m_irq = 0; m_cycles = 0;
        for (int s = 0; s < SYNC; s++) m_pipe[s] = 0;
    endtask

    // One bus cycle: drive, take the rising edge, advance the model, settle past the edge.
    task automatic step(input logic c, input logic w, input logic [2:0] idx,
                        input logic [1:0] lane, input logic [7:0] d);
        logic [31:0] last, hit, mask, wd, val;
        int lo;
        bus.cs = c; bus.we = w; bus.rs = {idx, lane}; bus.din = d;
        gpio_i = pins[WIDTH-1:0];
        @(posedge clk);
        last = m_pipe[SYNC-1];
        hit  = 0;
        if (m_cycles >= SYNC + 1) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (m_both[i])      hit[i] = last[i] ^ m_prev[i];
                else if (m_edge[i]) hit[i] = m_prev[i] & ~last[i];
                else                hit[i] = ~m_prev[i] & last[i];
            end
        end
        lo   = 8 * int'(lane);
        mask = (lo < WIDTH) ? ((32'hFF << lo) & WMASK) : 32'h0;
        wd   = ({24'h0, d} << lo) & mask;
        m_irq = |(m_stat & m_ien);
        if (c && !w) begin
            val    = m_reg(int'(idx)) >> lo;
            m_dout = (lo < WIDTH) ? val[7:0] : 8'h00;
        end
        if (c && w) begin
            case (idx)
                3'd0: m_out  = (m_out  & ~mask) | wd;
                3'd1: m_dir  = (m_dir  & ~mask) | wd;
                3'd3: m_ien  = (m_ien  & ~mask) | wd;
                3'd4: m_edge = (m_edge & ~mask) | wd;
                3'd5: m_both = (m_both & ~mask) | wd;
                3'd6: m_stat = m_stat & ~wd;
                default: ;
            endcase
        end
        m_stat = m_stat | hit;
        for (int s = SYNC - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = pins & WMASK;
        m_prev    = last;
        m_cycles++;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
    endtask

    task automatic apply_reset();
        bus.cs = 0; bus.we = 0; bus.rs = 0; bus.din = 0;
        gpio_i = pins[WIDTH-1:0];
        reset = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (gpio_o !== OUT_RST) begin errors++; $display("[TB] FAIL reset_gpio_o got %0h want %0h", gpio_o, OUT_RST); end
        checks++; if (gpio_oe !== 12'h000) begin errors++; $display("[TB] FAIL reset_gpio_oe got %0h want 0", gpio_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %0b want 0", irq); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got %0h want 0", bus.dout); end
    endtask

    task automatic test_out_rw();
        step(1, 1, 3'd0, 2'd0, 8'hAB);
        step(1, 1, 3'd0, 2'd1, 8'h0F);
        checks++; if (gpio_o !== 12'hFAB) begin errors++; $display("[TB] FAIL out_value got %0h want fab", gpio_o); end
        step(1, 1, 3'd0, 2'd2, 8'hFF);
        checks++; if (gpio_o !== 12'hFAB) begin errors++; $display("[TB] FAIL out_lane2_ignored got %0h want fab", gpio_o); end
        step(1, 0, 3'd0, 2'd1, 8'h00);
        checks++; if (bus.dout !== 8'h0F) begin errors++; $display("[TB] FAIL out_read_lane1 got %0h want 0f", bus.dout); end
        idle();
        checks++; if (bus.dout !== 8'h0F) begin errors++; $display("[TB] FAIL dout_hold got %0h want 0f", bus.dout); end
        step(1, 0, 3'd0, 2'd2, 8'h00);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL out_read_lane2 got %0h want 00", bus.dout); end
        step(1, 0, 3'd7, 2'd0, 8'h00);
        checks++; if (bus.dout !== m_dout) begin errors++; $display("[TB] FAIL reg7_read got %0h want %0h", bus.dout, m_dout); end
    endtask

    task automatic test_dir_pin();
        step(1, 1, 3'd1, 2'd0, 8'h0F);
        checks++; if (gpio_oe !== 12'h00F) begin errors++; $display("[TB] FAIL dir_oe got %0h want 00f", gpio_oe); end
        pins = 32'h05A;
        repeat (SYNC) idle();
        step(1, 0, 3'd2, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h5A) begin errors++; $display("[TB] FAIL pin_read got %0h want 5a", bus.dout); end
    endtask

    task automatic test_rising_irq();
        pins = 32'h0;
        repeat (4) idle();
        step(1, 1, 3'd6, 2'd0, 8'hFF);
        step(1, 1, 3'd6, 2'd1, 8'hFF);
        step(1, 1, 3'd4, 2'd0, 8'h00);
        step(1, 1, 3'd5, 2'd0, 8'h00);
        step(1, 1, 3'd3, 2'd0, 8'h01);
        pins = 32'h001;
        repeat (SYNC + 1) idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_lag got %0b want 0", irq); end
        idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise got %0b want 1", irq); end
        step(1, 0, 3'd6, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h01) begin errors++; $display("[TB] FAIL stat_rise got %0h want 01", bus.dout); end
        step(1, 1, 3'd6, 2'd0, 8'h01);
        idle();
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_w1c got %0b want 0", irq); end
    endtask

    task automatic test_both_set_wins();
        step(1, 1, 3'd5, 2'd0, 8'h02);
        pins = 32'h003;
        repeat (SYNC + 2) idle();
        step(1, 1, 3'd6, 2'd0, 8'h02);
        step(1, 0, 3'd6, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL stat_cleared got %0h want 00", bus.dout); end
        pins = 32'h001;
        idle();
        repeat (SYNC - 1) idle();
        step(1, 1, 3'd6, 2'd0, 8'h02);
        step(1, 0, 3'd6, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h02) begin errors++; $display("[TB] FAIL set_wins got %0h want 02", bus.dout); end
    endtask

    task automatic test_arming();
        pins = 32'hFFF;
        apply_reset();
        repeat (SYNC + 4) idle();
        step(1, 0, 3'd6, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL arm_stat_lo got %0h want 00", bus.dout); end
        step(1, 0, 3'd6, 2'd1, 8'h00);
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL arm_stat_hi got %0h want 00", bus.dout); end
        step(1, 1, 3'd4, 2'd0, 8'h08);
        pins = 32'hFF7;
        repeat (SYNC + 1) idle();
        step(1, 0, 3'd6, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h08) begin errors++; $display("[TB] FAIL fall_stat got %0h want 08", bus.dout); end
    endtask

    task automatic test_reset_mid_write();
        step(1, 1, 3'd3, 2'd0, 8'h08);
        idle();
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ien_late_irq got %0b want 1", irq); end
        step(1, 1, 3'd0, 2'd0, 8'h55);
        step(1, 0, 3'd0, 2'd0, 8'h00);
        checks++; if (bus.dout !== 8'h55) begin errors++; $display("[TB] FAIL pre_reset_dout got %0h want 55", bus.dout); end
        bus.cs = 1; bus.we = 1; bus.rs = 5'd0; bus.din = 8'hFF;
        #3 reset = 1'b1;
        #1;
        m_reset();
        checks++; if (gpio_o !== OUT_RST) begin errors++; $display("[TB] FAIL midrst_gpio_o got %0h want %0h", gpio_o, OUT_RST); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq got %0b want 0", irq); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("[TB] FAIL midrst_dout got %0h want 00", bus.dout); end
        @(posedge clk);
        #1;
        checks++; if (gpio_o !== OUT_RST) begin errors++; $display("[TB] FAIL midrst_write_lost got %0h want %0h", gpio_o, OUT_RST); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic c, w;
        logic [2:0] idx;
        logic [1:0] lane;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) pins = $urandom & WMASK;
            c    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            idx  = 3'($urandom_range(0, 7));
            lane = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            step(c, w, idx, lane, d);
            checks++; if (bus.dout !== m_dout) begin errors++; $display("[TB] FAIL rand_dout n=%0d got %0h want %0h", n, bus.dout, m_dout); end
            checks++; if (gpio_o !== m_out[WIDTH-1:0]) begin errors++; $display("[TB] FAIL rand_gpio_o n=%0d got %0h want %0h", n, gpio_o, m_out[WIDTH-1:0]); end
            checks++; if (gpio_oe !== m_dir[WIDTH-1:0]) begin errors++; $display("[TB] FAIL rand_gpio_oe n=%0d got %0h want %0h", n, gpio_oe, m_dir[WIDTH-1:0]); end
            checks++; if (irq !== m_irq) begin errors++; $display("[TB] FAIL rand_irq n=%0d got %0b want %0b", n, irq, m_irq); end
        end
    endtask

    initial begin
        bus.cs = 0; bus.we = 0; bus.rs = 0; bus.din = 0;
        gpio_i = '0;
        test_reset();
        test_out_rw();
        test_dir_pin();
        test_rising_irq();
        test_both_set_wins();
        test_arming();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
